// File: rtl/ponteh_pwm.sv
// H-bridge PWM driver: prescaled PWM counter, shadowed duty and a dead-time FSM between drive modes.
// Optional soft-start duty ramp is enabled by defining PONTEH_SOFTSTART_EN.
module ponteh_pwm #(
  parameter int unsigned PW = 8,
  parameter int unsigned DW = 4,
  parameter int unsigned DT = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WE,
  input  logic [1:0]    RGT,
  input  logic [PW-1:0] VLR,
  output logic          SA,
  output logic          SH,
  output logic          BRK,
  output logic          BSY
);

  localparam int unsigned DCW = (DT > 1) ? $clog2(DT) : 1;

  typedef enum logic [2:0] {StIdle, StDrvA, StDrvH, StBrake, StDead} state_e;

  state_e          state_q, state_d, target;
  logic [1:0]      ope_q, ope_d;
  logic [DW-1:0]   div_q, div_d;
  logic [PW-1:0]   cmo_q, cmo_d;
  logic [PW-1:0]   duty_q, duty_d;
  logic [DW-1:0]   psc_q, psc_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic [DCW-1:0]  dead_q, dead_d;
  logic            sa_q, sa_d, sh_q, sh_d, brk_q, brk_d, bsy_q, bsy_d;
  logic            tick, wrap, pwm_on, dead_done;
`ifdef PONTEH_SOFTSTART_EN
  logic [PW-1:0]   eff_q, eff_d;
`endif

  always_comb begin
    unique case (ope_q)
      2'b01:   target = StDrvA;
      2'b10:   target = StDrvH;
      2'b11:   target = StBrake;
      default: target = StIdle;
    endcase
  end

  assign tick      = (psc_q == div_q);
  assign wrap      = tick && (cnt_q == {PW{1'b1}});
  assign dead_done = (dead_q == DCW'(DT - 1));

`ifdef PONTEH_SOFTSTART_EN
  assign pwm_on = (cnt_q < eff_q);
`else
  assign pwm_on = (cnt_q < duty_q);
`endif

  always_comb begin
    ope_d   = ope_q;
    div_d   = div_q;
    cmo_d   = cmo_q;
    duty_d  = duty_q;
    psc_d   = tick ? '0 : psc_q + DW'(1);
    cnt_d   = tick ? cnt_q + PW'(1) : cnt_q;
    dead_d  = dead_q;
    state_d = state_q;
`ifdef PONTEH_SOFTSTART_EN
    eff_d   = eff_q;
`endif

    if (wrap) begin
      duty_d = cmo_q;
`ifdef PONTEH_SOFTSTART_EN
      // Ramp one step per period, but never sit above the new shadow duty.
      eff_d = (eff_q < cmo_q) ? eff_q + PW'(1) : cmo_q;
`endif
    end

    if (state_q == StDead) begin
      dead_d = dead_q + DCW'(1);
      if (dead_done) begin
        state_d = target;
        dead_d  = '0;
        if (target == StDrvA || target == StDrvH) begin
          psc_d  = '0;
          cnt_d  = '0;
          duty_d = cmo_q;
`ifdef PONTEH_SOFTSTART_EN
          eff_d  = '0;
`endif
        end
      end
    end else if (target != state_q) begin
      state_d = StDead;
      dead_d  = '0;
    end

    if (WE) begin
      unique case (RGT)
        2'b00: ope_d = VLR[1:0];
        2'b01: begin
          div_d = VLR[DW-1:0];
          psc_d = '0;
        end
        2'b10: cmo_d = VLR;
        default: ;
      endcase
    end

    sa_d  = (state_q == StDrvA) && pwm_on;
    sh_d  = (state_q == StDrvH) && pwm_on;
    brk_d = (state_q == StBrake);
    bsy_d = (state_q == StDead);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      ope_q   <= '0;
      div_q   <= '0;
      cmo_q   <= '0;
      duty_q  <= '0;
      psc_q   <= '0;
      cnt_q   <= '0;
      dead_q  <= '0;
      sa_q    <= 1'b0;
      sh_q    <= 1'b0;
      brk_q   <= 1'b0;
      bsy_q   <= 1'b0;
`ifdef PONTEH_SOFTSTART_EN
      eff_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ope_q   <= ope_d;
      div_q   <= div_d;
      cmo_q   <= cmo_d;
      duty_q  <= duty_d;
      psc_q   <= psc_d;
      cnt_q   <= cnt_d;
      dead_q  <= dead_d;
      sa_q    <= sa_d;
      sh_q    <= sh_d;
      brk_q   <= brk_d;
      bsy_q   <= bsy_d;
`ifdef PONTEH_SOFTSTART_EN
      eff_q   <= eff_d;
`endif
    end
  end

  assign SA  = sa_q;
  assign SH  = sh_q;
  assign BRK = brk_q;
  assign BSY = bsy_q;

endmodule
